// File: rtl/toy_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : toy_mem_arb
// Purpose  : Two-port arbiter in front of one single-port synchronous memory
//            (1-cycle read latency). Port 0 is the instruction-fetch reader,
//            port 1 is the loader/debug reader/writer. One access is granted
//            per cycle; read data returns to the granted port one cycle later.
// Config   : TOY_MEM_ARB_RR_EN defined   -> round-robin arbitration.
//            TOY_MEM_ARB_RR_EN undefined -> fixed priority to port 0 with a
//                                           port 1 anti-starvation counter.
// Revision : 1.0 - initial release
// ============================================================================
module toy_mem_arb #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // port 0 : instruction fetch (read only)
  input  logic                    p0_req_vld,
  output logic                    p0_req_rdy,
  input  logic [ADDR_WIDTH-1:0]   p0_req_addr,
  output logic                    p0_rsp_vld,
  output logic [DATA_WIDTH-1:0]   p0_rsp_data,
  // port 1 : loader / debug (read / write)
  input  logic                    p1_req_vld,
  output logic                    p1_req_rdy,
  input  logic [ADDR_WIDTH-1:0]   p1_req_addr,
  input  logic                    p1_req_wr_en,
  input  logic [DATA_WIDTH-1:0]   p1_req_wr_data,
  input  logic [DATA_WIDTH/8-1:0] p1_req_wr_be,
  output logic                    p1_rsp_vld,
  output logic [DATA_WIDTH-1:0]   p1_rsp_data,
  // memory macro side
  output logic                    mem_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wr_en,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [DATA_WIDTH/8-1:0] mem_wr_byte_en,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

  localparam int   BE_WIDTH = DATA_WIDTH / 8;
  localparam logic PORT0    = 1'b0;
  localparam logic PORT1    = 1'b1;

  // Grant decisions for the current cycle (at most one is high).
  logic gnt0;
  logic gnt1;

  // A grant that will return data next cycle.
  logic rd_grant;

  // Response tag: one outstanding read at most, so a single entry suffices.
  logic tag_vld;
  logic tag_port;

  // Last driven address / write data, so the memory bus stays still when idle.
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_wr_data;

`ifdef TOY_MEM_ARB_RR_EN
  // --------------------------------------------------------------------------
  // Round-robin arbitration: rr_ptr names the preferred port on contention.
  // --------------------------------------------------------------------------
  logic rr_ptr;

  // Pick a winner; nothing is granted while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (p0_req_vld && p1_req_vld) begin
        gnt0 = (rr_ptr == PORT0);
        gnt1 = (rr_ptr == PORT1);
      end else begin
        gnt0 = p0_req_vld;
        gnt1 = p1_req_vld;
      end
    end
  end

  // Move the preference to the other port after every grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= PORT0;
    end else if (gnt0) begin
      rr_ptr <= PORT1;
    end else if (gnt1) begin
      rr_ptr <= PORT0;
    end
  end
`else
  // --------------------------------------------------------------------------
  // Fixed priority to port 0; port 1 is forced through once it has been
  // passed over STARVE_LIMIT consecutive cycles.
  // --------------------------------------------------------------------------
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_p1;

  assign force_p1 = (starve_cnt == CNT_MAX);

  // Pick a winner; port 1 overrides port 0 only when starved.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (p0_req_vld && p1_req_vld) begin
        gnt0 = !force_p1;
        gnt1 = force_p1;
      end else begin
        gnt0 = p0_req_vld;
        gnt1 = p1_req_vld;
      end
    end
  end

  // Count cycles port 1 waits behind port 0; clear on service or withdrawal.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!p1_req_vld || gnt1) begin
      starve_cnt <= '0;
    end else if (gnt0 && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Request handshake
  // --------------------------------------------------------------------------
  assign p0_req_rdy = gnt0;
  assign p1_req_rdy = gnt1;

  // Port 0 always reads; port 1 reads only when not writing.
  assign rd_grant = gnt0 || (gnt1 && !p1_req_wr_en);

  // --------------------------------------------------------------------------
  // Memory drive
  // --------------------------------------------------------------------------

  // Route the granted request to the macro; strobes are zero with no grant
  // because the macro writes on byte enables alone.
  always_comb begin
    mem_en         = 1'b0;
    mem_addr       = hold_addr;
    mem_wr_en      = 1'b0;
    mem_wr_data    = hold_wr_data;
    mem_wr_byte_en = '0;
    if (gnt0) begin
      mem_en   = 1'b1;
      mem_addr = p0_req_addr;
    end else if (gnt1) begin
      mem_en      = 1'b1;
      mem_addr    = p1_req_addr;
      mem_wr_data = p1_req_wr_data;
      if (p1_req_wr_en) begin
        mem_wr_en      = 1'b1;
        mem_wr_byte_en = p1_req_wr_be;
      end
    end
  end

  // Remember the last address and write data so idle cycles do not toggle them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_addr    <= '0;
      hold_wr_data <= '0;
    end else if (mem_en) begin
      hold_addr    <= mem_addr;
      hold_wr_data <= mem_wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Response routing
  // --------------------------------------------------------------------------

  // Capture which port owns the read data arriving next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld  <= 1'b0;
      tag_port <= PORT0;
    end else begin
      tag_vld <= rd_grant;
      if (rd_grant) begin
        tag_port <= gnt1 ? PORT1 : PORT0;
      end
    end
  end

  // Responses are suppressed while reset is held, so a read accepted just
  // before reset never surfaces.
  assign p0_rsp_vld  = rst_n && tag_vld && (tag_port == PORT0);
  assign p1_rsp_vld  = rst_n && tag_vld && (tag_port == PORT1);
  assign p0_rsp_data = mem_rd_data;
  assign p1_rsp_data = mem_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_toy_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_toy_mem_arb
// Purpose  : Directed self-checking bench for toy_mem_arb with a behavioural
//            byte-enable memory model attached to the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toy_mem_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          p0_req_vld;
  logic          p0_req_rdy;
  logic [AW-1:0] p0_req_addr;
  logic          p0_rsp_vld;
  logic [DW-1:0] p0_rsp_data;
  logic          p1_req_vld;
  logic          p1_req_rdy;
  logic [AW-1:0] p1_req_addr;
  logic          p1_req_wr_en;
  logic [DW-1:0] p1_req_wr_data;
  logic [BW-1:0] p1_req_wr_be;
  logic          p1_rsp_vld;
  logic [DW-1:0] p1_rsp_data;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wr_data;
  logic [BW-1:0] mem_wr_byte_en;
  logic [DW-1:0] mem_rd_data;

  logic          init_en;
  logic [DW-1:0] mem [0:255];

  int vec_cnt;
  int err_cnt;

  toy_mem_arb #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .p0_req_vld    (p0_req_vld),
    .p0_req_rdy    (p0_req_rdy),
    .p0_req_addr   (p0_req_addr),
    .p0_rsp_vld    (p0_rsp_vld),
    .p0_rsp_data   (p0_rsp_data),
    .p1_req_vld    (p1_req_vld),
    .p1_req_rdy    (p1_req_rdy),
    .p1_req_addr   (p1_req_addr),
    .p1_req_wr_en  (p1_req_wr_en),
    .p1_req_wr_data(p1_req_wr_data),
    .p1_req_wr_be  (p1_req_wr_be),
    .p1_rsp_vld    (p1_rsp_vld),
    .p1_rsp_data   (p1_rsp_data),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_byte_en(mem_wr_byte_en),
    .mem_rd_data   (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: writes on byte enables alone, reads registered on mem_en.
  always @(posedge clk) begin
    if (init_en) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'hAABBCCDD;
    end else begin
      if (mem_en) mem_rd_data <= mem[mem_addr[7:0]];
      for (int b = 0; b < BW; b++) begin
        if (mem_wr_byte_en[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wr_data[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Deassert both requests and load junk into port 1 data fields.
  task automatic idle_inputs();
    p0_req_vld     = 1'b0;
    p0_req_addr    = 32'h0000_0044;
    p1_req_vld     = 1'b0;
    p1_req_addr    = 32'h0000_0010;
    p1_req_wr_en   = 1'b1;
    p1_req_wr_data = 32'h5A5A_5A5A;
    p1_req_wr_be   = 4'hF;
  endtask

  // Grant expected for port 1 at step k of a contended run.
  function automatic logic exp_p1(input int k);
`ifdef TOY_MEM_ARB_RR_EN
    return (k % 2) == 1;
`else
    return (k % 9) == 8;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev;
    vec_cnt = 0;
    err_cnt = 0;
    init_en = 1'b1;
    rst_n   = 1'b0;
    idle_inputs();

    // Reset with active requests: everything quiet.
    @(negedge clk);
    init_en      = 1'b0;
    p0_req_vld   = 1'b1;
    p0_req_addr  = 32'h10;
    p1_req_vld   = 1'b1;
    #1;
    check("rst_p0_rdy", p0_req_rdy, 0);
    check("rst_p1_rdy", p1_req_rdy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_be", mem_wr_byte_en, 0);

    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    #1;
    check("rst_p0_rsp", p0_rsp_vld, 0);
    check("rst_p1_rsp", p1_rsp_vld, 0);

    // Test 1: port 0 read.
    @(negedge clk);
    p0_req_vld  = 1'b1;
    p0_req_addr = 32'h10;
    #1;
    check("t1_p0_rdy", p0_req_rdy, 1);
    check("t1_p1_rdy", p1_req_rdy, 0);
    check("t1_mem_en", mem_en, 1);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_wr_en", mem_wr_en, 0);
    check("t1_be", mem_wr_byte_en, 0);
    @(negedge clk);
    #1;
    check("t1_rsp_vld", p0_rsp_vld, 1);
    check("t1_rsp_data", p0_rsp_data, 32'hDEADBEEF);
    check("t1_p1_rsp", p1_rsp_vld, 0);

    // Test 2: port 1 partial write then read-back.
    idle_inputs();
    p1_req_vld     = 1'b1;
    p1_req_addr    = 32'h20;
    p1_req_wr_en   = 1'b1;
    p1_req_wr_data = 32'h11223344;
    p1_req_wr_be   = 4'b0011;
    #1;
    check("t2_p1_rdy", p1_req_rdy, 1);
    check("t2_mem_addr", mem_addr, 32'h20);
    check("t2_wr_en", mem_wr_en, 1);
    check("t2_be", mem_wr_byte_en, 4'b0011);
    check("t2_wr_data", mem_wr_data, 32'h11223344);
    @(negedge clk);
    #1;
    check("t2_wr_no_rsp1", p1_rsp_vld, 0);
    check("t2_wr_no_rsp0", p0_rsp_vld, 0);
    p1_req_wr_en = 1'b0;
    #1;
    check("t2_rd_rdy", p1_req_rdy, 1);
    check("t2_rd_wr_en", mem_wr_en, 0);
    check("t2_rd_be", mem_wr_byte_en, 0);
    @(negedge clk);
    #1;
    check("t2_rsp_vld", p1_rsp_vld, 1);
    check("t2_rsp_data", p1_rsp_data, 32'hAABB3344);
    check("t2_p0_rsp", p0_rsp_vld, 0);
    idle_inputs();

    // Test 4: idle cycles keep the memory strobes off.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("t4_mem_en", mem_en, 0);
      check("t4_be", mem_wr_byte_en, 0);
      check("t4_wr_en", mem_wr_en, 0);
      check("t4_rsp", {p0_rsp_vld, p1_rsp_vld}, 2'b00);
    end
    @(negedge clk);
    p0_req_vld  = 1'b1;
    p0_req_addr = 32'h10;
    #1;
    check("t4_rd10_rdy", p0_req_rdy, 1);
    @(negedge clk);
    #1;
    check("t4_rd10_vld", p0_rsp_vld, 1);
    check("t4_rd10_data", p0_rsp_data, 32'hDEADBEEF);
    p0_req_addr = 32'h20;
    #1;
    check("t4_rd20_rdy", p0_req_rdy, 1);
    @(negedge clk);
    #1;
    check("t4_rd20_vld", p0_rsp_vld, 1);
    check("t4_rd20_data", p0_rsp_data, 32'hAABB3344);

    // Test 5: read accepted, then reset asserted the following cycle.
    p0_req_addr = 32'h10;
    #1;
    check("t5_grant", p0_req_rdy, 1);
    @(negedge clk);
    rst_n      = 1'b0;
    p1_req_vld = 1'b1;
    #1;
    check("t5_p0_rsp", p0_rsp_vld, 0);
    check("t5_p1_rsp", p1_rsp_vld, 0);
    check("t5_rdy", {p0_req_rdy, p1_req_rdy}, 2'b00);
    check("t5_mem_en", mem_en, 0);
    check("t5_be", mem_wr_byte_en, 0);
    check("t5_wr_en", mem_wr_en, 0);

    // Test 3 / 6: contended run straight out of reset.
    @(negedge clk);
    rst_n          = 1'b1;
    p0_req_vld     = 1'b1;
    p0_req_addr    = 32'h10;
    p1_req_vld     = 1'b1;
    p1_req_addr    = 32'h20;
    p1_req_wr_en   = 1'b0;
    #1;
    check("t5_after_rst_rsp", {p0_rsp_vld, p1_rsp_vld}, 2'b00);
    for (int k = 0; k < 27; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
        prev = exp_p1(k - 1);
        check("t3_rsp_p0", p0_rsp_vld, !prev);
        check("t3_rsp_p1", p1_rsp_vld, prev);
        check("t3_rsp_data", prev ? p1_rsp_data : p0_rsp_data,
              prev ? 32'hAABB3344 : 32'hDEADBEEF);
      end
      check("t3_p0_rdy", p0_req_rdy, !exp_p1(k));
      check("t3_p1_rdy", p1_req_rdy, exp_p1(k));
      check("t3_onehot", p0_req_rdy & p1_req_rdy, 0);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    prev = exp_p1(26);
    check("t3_last_p0", p0_rsp_vld, !prev);
    check("t3_last_p1", p1_rsp_vld, prev);
    @(negedge clk);
    #1;
    check("end_quiet", {p0_rsp_vld, p1_rsp_vld, mem_en}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
